kmeans_assign_accum: RTL and testbench
======================================

# kmeans_assign_accum

Parametrised nearest-mean assignment and accumulation engine for the K-means clustering datapath. It holds K cluster means and streams pixels through a two-stage pipeline. Each pixel is assigned to its nearest mean by L1 distance, and per-cluster channel sums and pixel counts are accumulated. At end of pass, the mean-update logic reads the totals back, so one pass equals one K-means iteration.

## Interface
- `K`, 16, number of clusters (2..16); `IDX_W = $clog2(K)`
- `CHANNELS`, 3, colour channels per pixel
- `CW`, 8, bits per channel
- `CNT_W`, 13, per-cluster pixel-count width

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `start` in 1: begin pass (sampled in IDLE only)
- `mean_we` in 1: write mean (IDLE only)
- `mean_idx` in IDX_W: mean to write
- `mean_data` in CHANNELS*CW: mean value, channel 0 in LSBs
- `pix_valid` in 1: pixel present
- `pix_data` in CHANNELS*CW: pixel, channel 0 in LSBs
- `pix_last` in 1: final pixel of pass, qualified by `pix_valid & pix_ready`
- `pix_ready` out 1: pixel accepted when high with `pix_valid`
- `label_valid` out 1: assignment result valid
- `label` out IDX_W: assigned cluster
- `rd_en` in 1: readout request
- `rd_idx` in IDX_W: cluster to read
- `rd_valid` out 1: readout data valid
- `rd_sum` out CHANNELS*(CW+CNT_W): channel sums
- `rd_count` out CNT_W: pixel count
- `strb` out 1: one-cycle pass-complete pulse
- `ovf` out 1: sticky count saturation in current pass
- `state` out 2: FSM state

## Operation
- **States:**
  - IDLE=0: `pix_ready`=0; `mean_we` honoured; `start` clears all sums, counts and `ovf`, then enters STREAM.
  - STREAM=1: `pix_ready`=1. Accepting `pix_last` enters DRAIN.
  - DRAIN=2: `pix_ready`=0. Stays until both pipeline stages are empty.
  - DONE=3: `strb`=1 for exactly one cycle, then IDLE.
- **Distance:** sum over channels of |p_c − m_c|, width CW+$clog2(CHANNELS), no truncation. Argmin breaks ties to the lowest index.
- **Accumulation:** the winning cluster adds the pixel to each channel sum and adds 1 to its count. If the count is already 2^CNT_W−1, that cluster's sum and count freeze and `ovf` sets; `ovf` stays set until the next `start`.
- **Ignored inputs:**
  - `start` outside IDLE.
  - `mean_we` outside IDLE.
  - `mean_idx` ≥ K.
  - `rd_idx` ≥ K returns zeros.
- **Readout:** legal in any state and returns live accumulator values.
- **Reset values:**
  - State IDLE; all outputs 0.
  - Sums, counts and pipeline cleared.
  - Mean i, every channel = i << (CW − IDX_W); for K=16, CW=8 this is i*16.
- **Reset mid-pass:** everything returns to the reset values immediately, and no `strb` is issued.

## Timing
- **Pixel path:**
  - Pixel accepted at edge t.
  - Stage 1 registers the pixel; stage 2 registers the distance argmin.
  - `label_valid`/`label` are high in cycle t+2.
  - The accumulator updates at edge t+2 and is visible on readout from t+3.
- **Throughput:** one pixel per cycle; `pix_valid` gaps are allowed.
- **Pass end:** if `pix_last` is accepted at edge t, DRAIN covers cycles t+1..t+2 and `strb` is high in cycle t+3.
- **`start`:** sampled at edge s, so the first `pix_ready`=1 is in cycle s+1.
- **Readout:** `rd_en` at edge r gives `rd_valid`/`rd_sum`/`rd_count` in cycle r+1, held until the next `rd_en`. `rd_valid` drops after one cycle.
- **Mean writes:** a write at edge w affects pixels accepted at edge w+1 or later.

## Configuration
- **`KMEANS_ASSIGN_LABEL_EN`:**
  - Defined: `label_valid`/`label` are driven as specified.
  - Undefined: both are tied to 0 and the stage-2 label register is removed. Accumulation is unchanged.

## Test plan
Default parameters apply unless a scenario says otherwise.
- **Reset:** release `reset`, then read `rd_idx`=5. Expect `state`=0, `pix_ready`=0, `strb`=0, `rd_sum`=0, `rd_count`=0.
- **Single pixel:** `start`, then pixel 0x202020 with `pix_last`. Expect `label`=2 two cycles after acceptance and `strb` three cycles after acceptance. Readout of cluster 2 gives count 1 and each channel sum 0x20.
- **Tie:** pixel 0x181818 is distance 24 from both mean 1 and mean 2. Expect `label`=1.
- **Long pass:**
  - Load mean 3 = 0xF5F5F5 while IDLE, then stream 200 pixels of 0xF5F5F5 with random `pix_valid` gaps.
  - Expect `label`=3 on every pixel, count[3]=200, each channel sum 49000, and exactly one `strb`.
  - A `start` or `mean_we` issued mid-stream has no effect.
- **Saturation** (`CNT_W`=4): stream 20 pixels of 0x000000. Expect count[0]=15 and `ovf`=1 from the 16th pixel on; the next `start` clears `ovf`.
- **Reset mid-pass:** assert `reset` after 50 of 100 pixels. Expect immediate `state`=0, all counts 0, default means restored, and no `strb`.

Source files
------------

// File: rtl/kmeans_assign_accum.sv
// Nearest-mean (L1) assignment and per-cluster sum/count accumulation, one K-means pass per run.
// Define KMEANS_ASSIGN_LABEL_EN to drive label_valid/label; otherwise both are tied to 0.
module kmeans_assign_accum #(
  parameter  int K        = 16,
  parameter  int CHANNELS = 3,
  parameter  int CW       = 8,
  parameter  int CNT_W    = 13,
  localparam int IDX_W    = $clog2(K),
  localparam int PIX_W    = CHANNELS * CW,
  localparam int SUM_W    = CW + CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mean_we,
  input  logic [IDX_W-1:0]          mean_idx,
  input  logic [PIX_W-1:0]          mean_data,
  input  logic                      pix_valid,
  input  logic [PIX_W-1:0]          pix_data,
  input  logic                      pix_last,
  output logic                      pix_ready,
  output logic                      label_valid,
  output logic [IDX_W-1:0]          label,
  input  logic                      rd_en,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      rd_valid,
  output logic [CHANNELS*SUM_W-1:0] rd_sum,
  output logic [CNT_W-1:0]          rd_count,
  output logic                      strb,
  output logic                      ovf,
  output logic [1:0]                state
);

  localparam int DIST_W = CW + $clog2(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t             st;
  logic [PIX_W-1:0]   means  [K];
  logic [SUM_W-1:0]   sums   [K][CHANNELS];
  logic [CNT_W-1:0]   counts [K];
  logic               s1_valid, s2_valid;
  logic [PIX_W-1:0]   s1_pix, s2_pix;
  logic [IDX_W-1:0]   s2_idx;
  logic [IDX_W-1:0]   best_idx;
  logic [DIST_W-1:0]  best_dist, dist_k;
  logic               accept;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    if (K == (1 << IDX_W)) return 1'b1;
    return ({1'b0, idx} < (IDX_W+1)'(K));
  endfunction

  function automatic logic [PIX_W-1:0] mean_init(input int k);
    logic [CW-1:0] ch;
    ch = CW'(k << (CW - IDX_W));
    return {CHANNELS{ch}};
  endfunction

  function automatic logic [DIST_W-1:0] l1_dist(input logic [PIX_W-1:0] p, input logic [PIX_W-1:0] m);
    logic [DIST_W-1:0] acc;
    logic [CW-1:0]     pc, mc, d;
    acc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pc  = p[c*CW +: CW];
      mc  = m[c*CW +: CW];
      d   = (pc > mc) ? pc - mc : mc - pc;
      acc = acc + DIST_W'(d);
    end
    return acc;
  endfunction

  assign state     = st;
  assign pix_ready = (st == STREAM);
  assign strb      = (st == DONE);
  assign accept    = pix_valid && pix_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE:    if (start) st <= STREAM;
        STREAM:  if (accept && pix_last) st <= DRAIN;
        // Stage 2 empties on this same edge, so only stage 1 must already be empty.
        DRAIN:   if (!s1_valid) st <= DONE;
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  // NOTE: the mean table carries a reset value, so it is built from flops rather than a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < K; k++) means[k] <= mean_init(k);
    end else if (st == IDLE && mean_we && idx_ok(mean_idx)) begin
      means[mean_idx] <= mean_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    best_idx  = '0;
    best_dist = l1_dist(s1_pix, means[0]);
    dist_k    = '0;
    for (int k = 1; k < K; k++) begin
      dist_k = l1_dist(s1_pix, means[k]);
      if (dist_k < best_dist) begin
        best_dist = dist_k;
        best_idx  = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s2_valid <= 1'b0;
      s2_pix   <= '0;
      s2_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_pix <= pix_data;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pix <= s1_pix;
        s2_idx <= best_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < K; k++) begin
        counts[k] <= '0;
        for (int c = 0; c < CHANNELS; c++) sums[k][c] <= '0;
      end
      ovf <= 1'b0;
    end else if (st == IDLE && start) begin
      for (int k = 0; k < K; k++) begin
        counts[k] <= '0;
        for (int c = 0; c < CHANNELS; c++) sums[k][c] <= '0;
      end
      ovf <= 1'b0;
    end else if (s2_valid) begin
      // A saturated cluster freezes entirely so its mean stays a consistent sum/count ratio.
      if (counts[s2_idx] == CNT_MAX) begin
        ovf <= 1'b1;
      end else begin
        counts[s2_idx] <= counts[s2_idx] + CNT_W'(1);
        for (int c = 0; c < CHANNELS; c++)
          sums[s2_idx][c] <= sums[s2_idx][c] + SUM_W'(s2_pix[c*CW +: CW]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_sum   <= '0;
      rd_count <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (idx_ok(rd_idx)) begin
          rd_count <= counts[rd_idx];
          for (int c = 0; c < CHANNELS; c++) rd_sum[c*SUM_W +: SUM_W] <= sums[rd_idx][c];
        end else begin
          rd_count <= '0;
          rd_sum   <= '0;
        end
      end
    end
  end

`ifdef KMEANS_ASSIGN_LABEL_EN
  assign label_valid = s2_valid;
  assign label       = s2_idx;
`else
  assign label_valid = 1'b0;
  assign label       = '0;
`endif

endmodule

// File: tb/tb_kmeans_assign_accum.sv
// Scoreboard bench for kmeans_assign_accum: directed pixels, queued expectations, negedge monitor.
module tb_kmeans_assign_accum;

  localparam int K = 16, CH = 3, CW = 8, CNT_W = 13, IDX_W = 4;
  localparam int PIX_W = CH * CW, SUM_W = CW + CNT_W;
  localparam int S_CNT_W = 4, S_SUM_W = CW + S_CNT_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                  start, mean_we, pix_valid, pix_last, pix_ready, label_valid;
  logic [IDX_W-1:0]      mean_idx, label, rd_idx;
  logic [PIX_W-1:0]      mean_data, pix_data;
  logic                  rd_en, rd_valid, strb, ovf;
  logic [CH*SUM_W-1:0]   rd_sum;
  logic [CNT_W-1:0]      rd_count;
  logic [1:0]            state;

  logic                  s_start, s_mean_we, s_pix_valid, s_pix_last, s_pix_ready, s_label_valid;
  logic [IDX_W-1:0]      s_mean_idx, s_label, s_rd_idx;
  logic [PIX_W-1:0]      s_mean_data, s_pix_data;
  logic                  s_rd_en, s_rd_valid, s_strb, s_ovf;
  logic [CH*S_SUM_W-1:0] s_rd_sum;
  logic [S_CNT_W-1:0]    s_rd_count;
  logic [1:0]            s_state;

  kmeans_assign_accum dut (
    .clk(clk), .reset(reset), .start(start), .mean_we(mean_we), .mean_idx(mean_idx),
    .mean_data(mean_data), .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .pix_ready(pix_ready), .label_valid(label_valid), .label(label), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_sum(rd_sum), .rd_count(rd_count),
    .strb(strb), .ovf(ovf), .state(state)
  );

  kmeans_assign_accum #(.CNT_W(S_CNT_W)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .mean_we(s_mean_we), .mean_idx(s_mean_idx),
    .mean_data(s_mean_data), .pix_valid(s_pix_valid), .pix_data(s_pix_data), .pix_last(s_pix_last),
    .pix_ready(s_pix_ready), .label_valid(s_label_valid), .label(s_label), .rd_en(s_rd_en),
    .rd_idx(s_rd_idx), .rd_valid(s_rd_valid), .rd_sum(s_rd_sum), .rd_count(s_rd_count),
    .strb(s_strb), .ovf(s_ovf), .state(s_state)
  );

  typedef struct { logic [IDX_W-1:0] lbl; int cyc; } lbl_exp_t;
  typedef struct { logic [CH*SUM_W-1:0] sum; logic [CNT_W-1:0] cnt; } rd_exp_t;

  lbl_exp_t lbl_q[$];
  int       strb_q[$];
  rd_exp_t  rd_q[$];

  int total = 0, bad = 0, cyc = 0, strb_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CH*SUM_W-1:0] pack(input int c0, input int c1, input int c2);
    return {SUM_W'(c2), SUM_W'(c1), SUM_W'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_start", 64'(pix_ready), 64'd1);
  endtask

  task automatic send_pixel(input logic [PIX_W-1:0] data, input logic last, input logic [IDX_W-1:0] exp_lbl);
    int n = 0;
    while (!pix_ready && n < 50) begin
      tick();
      n++;
    end
    if (!pix_ready) begin
      check("ready_timeout", 64'(pix_ready), 64'd1);
      return;
    end
    pix_valid = 1'b1;
    pix_data  = data;
    pix_last  = last;
`ifdef KMEANS_ASSIGN_LABEL_EN
    lbl_q.push_back('{exp_lbl, cyc + 2});
`else
    if (exp_lbl != exp_lbl) $display("unreachable");
`endif
    if (last) strb_q.push_back(cyc + 3);
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state != 2'd0 && n < 20) begin
      tick();
      n++;
    end
    check("pass_back_to_idle", 64'(state), 64'd0);
  endtask

  task automatic read(input logic [IDX_W-1:0] idx, input logic [CH*SUM_W-1:0] s, input logic [CNT_W-1:0] c);
    rd_en  = 1'b1;
    rd_idx = idx;
    rd_q.push_back('{s, c});
    tick();
    rd_en = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    lbl_exp_t le;
    rd_exp_t  re;
    int       sc;
    if (reset) begin
      if (label_valid) begin
        if (lbl_q.size() == 0) check("label_unexpected", 64'(label_valid), 64'd0);
        else begin
          le = lbl_q.pop_front();
          check("label", 64'(label), 64'(le.lbl));
          check("label_cycle", 64'(cyc), 64'(le.cyc));
        end
      end
      if (strb) begin
        strb_seen++;
        if (strb_q.size() == 0) check("strb_unexpected", 64'(strb), 64'd0);
        else begin
          sc = strb_q.pop_front();
          check("strb_cycle", 64'(cyc), 64'(sc));
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'd0);
        else begin
          re = rd_q.pop_front();
          check("rd_sum", 64'(rd_sum), 64'(re.sum));
          check("rd_count", 64'(rd_count), 64'(re.cnt));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    start = 0; mean_we = 0; mean_idx = '0; mean_data = '0; pix_valid = 0; pix_data = '0;
    pix_last = 0; rd_en = 0; rd_idx = '0;
    s_start = 0; s_mean_we = 0; s_mean_idx = '0; s_mean_data = '0; s_pix_valid = 0;
    s_pix_data = '0; s_pix_last = 0; s_rd_en = 0; s_rd_idx = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_state", 64'(state), 64'd0);
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_strb", 64'(strb), 64'd0);
    check("rst_label_valid", 64'(label_valid), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    read(4'd5, '0, '0);
    tick();

    // Single pixel equal to mean 2
    start_pass();
    send_pixel(24'h202020, 1'b1, 4'd2);
    wait_idle();
    read(4'd2, pack(32, 32, 32), 13'd1);
    tick();
    check("rd_valid_drop", 64'(rd_valid), 64'd0);
    check("rd_count_hold", 64'(rd_count), 64'd1);
    read(4'd1, '0, '0);
    tick();

    // Tie and mixed-channel pixels
    start_pass();
    send_pixel(24'h181818, 1'b0, 4'd1);
    send_pixel(24'h00F010, 1'b0, 4'd1);
    send_pixel(24'h000007, 1'b0, 4'd0);
    send_pixel(24'hFFFFFF, 1'b1, 4'd15);
    wait_idle();
    read(4'd1, pack(8'h28, 9'h108, 8'h18), 13'd2);
    read(4'd0, pack(7, 0, 0), 13'd1);
    read(4'd15, pack(255, 255, 255), 13'd1);
    read(4'd2, '0, '0);
    tick();

    // Long pass with gaps; mid-stream start/mean_we must be ignored
    mean_we = 1'b1; mean_idx = 4'd3; mean_data = 24'hF5F5F5;
    tick();
    mean_we = 1'b0;
    s0 = strb_seen;
    start_pass();
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        start = 1'b1; mean_we = 1'b1; mean_idx = 4'd3; mean_data = '0;
        tick();
        start = 1'b0; mean_we = 1'b0;
      end
      send_pixel(24'hF5F5F5, i == 199, 4'd3);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    check("long_strb_count", 64'(strb_seen - s0), 64'd1);
    read(4'd3, pack(49000, 49000, 49000), 13'd200);
    read(4'd15, '0, '0);
    read(4'd0, '0, '0);
    tick();

    // Saturation on the CNT_W=4 instance
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      s_pix_valid = 1'b1;
      s_pix_last  = (i == 20);
      tick();
      s_pix_valid = 1'b0;
      s_pix_last  = 1'b0;
      tick();
      tick();
      check("sat_ovf", 64'(s_ovf), 64'(i >= 16));
    end
    s_rd_en = 1'b1; s_rd_idx = 4'd0;
    tick();
    s_rd_en = 1'b0;
    check("sat_rd_valid", 64'(s_rd_valid), 64'd1);
    check("sat_count", 64'(s_rd_count), 64'd15);
    check("sat_sum", 64'(s_rd_sum), 64'd0);
    repeat (3) tick();
    check("sat_idle", 64'(s_state), 64'd0);
    check("sat_ovf_sticky", 64'(s_ovf), 64'd1);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("sat_ovf_cleared", 64'(s_ovf), 64'd0);

    // Reset mid-pass: 50 of 100 pixels, then asynchronous reset
    start_pass();
    for (int i = 0; i < 50; i++) send_pixel(24'h303030, 1'b0, 4'd2);
    #2 reset = 1'b0;
    #1;
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_pix_ready", 64'(pix_ready), 64'd0);
    check("midrst_strb", 64'(strb), 64'd0);
    check("midrst_label_valid", 64'(label_valid), 64'd0);
    lbl_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    read(4'd2, '0, '0);
    read(4'd3, '0, '0);
    start_pass();
    send_pixel(24'h303030, 1'b1, 4'd3);
    wait_idle();
    read(4'd3, pack(48, 48, 48), 13'd1);
    tick();
    tick();

    check("label_q_drained", 64'(lbl_q.size()), 64'd0);
    check("strb_q_drained", 64'(strb_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
